// File: rtl/am_demod_tdm_sched.sv
// AM magnitude engine: floor(sqrt(I^2 + Q^2)) using one shared squarer
// over two cycles, then a restoring bit-serial square root.
module am_demod_tdm_sched #(
  parameter int WIDTH  = 12,
  parameter int DROP_W = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [WIDTH-1:0] I_in,
  input  logic signed [WIDTH-1:0] Q_in,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic        [WIDTH-1:0] d_out,
  output logic                    busy,
  output logic       [DROP_W-1:0] drop_cnt
);

  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [2:0] {IDLE, MUL_I, MUL_Q, SQRT, DONE} state_t;

  state_t                  state_q;
  logic signed [WIDTH-1:0] i_q, q_q;
  logic [2*WIDTH-1:0]      acc_q, rad_q;
  logic [WIDTH+1:0]        rem_q;
  logic [WIDTH-1:0]        root_q, d_out_q;
  logic [CNT_W-1:0]        bit_cnt_q;
  logic                    out_valid_q;
  logic [DROP_W-1:0]       drop_q;

  function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
    return (&v) ? v : v + DROP_W'(1);
  endfunction

  // Shared squarer: operand comes only from the latched sample registers.
  logic signed [WIDTH-1:0]   mul_op;
  logic signed [2*WIDTH-1:0] op_ext, prod;
  logic [2*WIDTH-1:0]        sq, sum;

  always_comb begin
    mul_op = (state_q == MUL_Q) ? q_q : i_q;
    op_ext = (2*WIDTH)'(mul_op);
    prod   = op_ext * op_ext;
    sq     = prod;
    sum    = acc_q + sq;
  end

  // One restoring square-root iteration.
  logic [WIDTH+3:0] rem_sh;
  logic [WIDTH+4:0] trial;
  logic             trial_ok;
  logic [WIDTH+1:0] rem_nxt;
  logic [WIDTH-1:0] root_nxt;

  always_comb begin
    rem_sh   = {rem_q, rad_q[2*WIDTH-1 -: 2]};
    trial    = {1'b0, rem_sh} - {3'b000, root_q, 2'b01};
    // A non-negative trial never exceeds the remainder width.
    trial_ok = (trial[WIDTH+4:WIDTH+2] == '0);
    rem_nxt  = trial_ok ? trial[WIDTH+1:0] : rem_sh[WIDTH+1:0];
    root_nxt = {root_q[WIDTH-2:0], trial_ok};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      i_q         <= '0;
      q_q         <= '0;
      acc_q       <= '0;
      rad_q       <= '0;
      rem_q       <= '0;
      root_q      <= '0;
      bit_cnt_q   <= '0;
      d_out_q     <= '0;
      out_valid_q <= 1'b0;
      drop_q      <= '0;
    end else begin
      if (in_valid && (state_q != IDLE)) drop_q <= sat_inc(drop_q);
      case (state_q)
        IDLE: if (in_valid) begin
          i_q     <= I_in;
          q_q     <= Q_in;
          state_q <= MUL_I;
        end
        MUL_I: begin
          acc_q   <= sq;
          state_q <= MUL_Q;
        end
        MUL_Q: begin
          acc_q     <= sum;
          rad_q     <= sum;
          rem_q     <= '0;
          root_q    <= '0;
          bit_cnt_q <= CNT_W'(WIDTH-1);
          state_q   <= SQRT;
        end
        SQRT: begin
          rem_q     <= rem_nxt;
          root_q    <= root_nxt;
          rad_q     <= rad_q << 2;
          bit_cnt_q <= bit_cnt_q - CNT_W'(1);
          if (bit_cnt_q == '0) begin
            d_out_q     <= root_nxt;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: if (out_ready) begin
          out_valid_q <= 1'b0;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign out_valid = out_valid_q;
  assign d_out     = d_out_q;
  assign drop_cnt  = drop_q;

endmodule

// File: doc/am_demod_tdm_sched.md
Name: am_demod_tdm_sched

Overview:
- Time-multiplexed AM magnitude engine: computes d_out = floor(sqrt(I^2 + Q^2)).
- Uses one shared signed multiplier, two cycles per sample, plus a bit-serial square root that produces one result bit per cycle.
- Sits between the decimating I/Q front end and the audio back end, replacing the two-multiplier pipelined demodulator in area-constrained builds.
- Uses a valid/ready handshake and counts input samples dropped while busy.

Parameters:
- WIDTH, 12, bit width of signed I/Q inputs and unsigned magnitude output.
- DROP_W, 16, width of saturating dropped-sample counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  I_in/Q_in carry a new sample.
- in_ready  output  1  block can accept a sample this cycle.
- I_in  input  WIDTH  signed in-phase sample.
- Q_in  input  WIDTH  signed quadrature sample.
- out_valid  output  1  d_out holds a result.
- out_ready  input  1  downstream accepts d_out.
- d_out  output  WIDTH  unsigned magnitude, floor of the true square root.
- busy  output  1  state is not IDLE.
- drop_cnt  output  DROP_W  count of samples offered while in_ready=0, saturating.

Behaviour:
- Reset (async assert, sync release): state=IDLE, in_ready=1, out_valid=0, d_out=0, busy=0, drop_cnt=0; all internal registers cleared. Reset mid-operation aborts the sample and discards any pending result.
- Internal registers:
  - iq_reg: I and Q latched at accept.
  - acc: unsigned, 2*WIDTH bits.
  - rad: radicand shift register.
  - rem: remainder, WIDTH+2 bits.
  - root: WIDTH bits.
  - bit_cnt.
- Shared multiplier: one signed WIDTH x WIDTH product per cycle. Operand mux selects I in MUL_I and Q in MUL_Q. There is no other multiplier instance.
- IDLE: in_ready=1. On in_valid=1, latch I/Q and go to MUL_I.
- MUL_I: acc <= I*I (non-negative, fits 2*WIDTH-1 bits). Go to MUL_Q.
- MUL_Q: acc <= acc + Q*Q. Max is 2^(2*WIDTH-1), so it fits 2*WIDTH bits with no overflow. Load rad <= acc + Q*Q, rem=0, root=0, bit_cnt=WIDTH-1. Go to SQRT.
- SQRT: restoring square root, one iteration per cycle, WIDTH cycles. Each cycle:
  - trial = {rem, rad[MSB:MSB-1]} - {root, 2'b01}.
  - If trial >= 0: rem <= trial, root <= {root, 1}.
  - Else: rem <= {rem, rad top 2 bits}, root <= {root, 0}.
  - rad shifts left by 2.
  - When bit_cnt=0: d_out <= final root, out_valid <= 1, go to DONE.
- DONE: out_valid=1 and d_out held stable. When out_ready=1, out_valid <= 0 and go to IDLE next edge. in_ready stays 0 in DONE.
- Latency: accept at edge k gives out_valid=1 after edge k+WIDTH+2 (14 cycles for WIDTH=12). Minimum initiation interval is WIDTH+4 cycles when out_ready is tied high.
- in_ready=1 only in IDLE, combinational from state. busy = (state != IDLE).
- Drop counter: drop_cnt increments on any cycle with in_valid=1 and in_ready=0, saturating at all ones. Accepted samples never count.
- Magnitude range: max result floor(sqrt(2^(2*WIDTH-1))) fits WIDTH bits (2896 for WIDTH=12). No clipping logic.
- The shared multiplier is never driven by an unaccepted sample.

Test Plan:
- Reset, then I=3, Q=4, in_valid for 1 cycle, out_ready=1 -> out_valid rises 14 cycles after accept; d_out=5; in_ready returns 1 one cycle after the handshake.
- I=-2048, Q=-2048 -> d_out=2896. I=0, Q=0 -> d_out=0. I=100, Q=0 -> 100. I=1, Q=1 -> 1 (floor).
- in_valid held high continuously with out_ready=1 -> one result every 16 cycles; drop_cnt increments by 15 per result.
- out_ready low 5 cycles after out_valid -> d_out and out_valid stable, in_ready=0 throughout; result consumed on the first out_ready=1 edge.
- Assert rst during SQRT (bit_cnt=6) -> all outputs reset immediately and no stale out_valid appears. A next sample I=-5, Q=12 -> 13.
- Force drop_cnt near saturation (DROP_W=4 build, 20 drops) -> drop_cnt holds at 15.
